cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/seq_wait_cnt.sv | 36 +++
 rtl/cpu_sequencer.sv | 158 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control sequencer: state encoding, opcode map
// and the default multiplier latency.
package cpu_pkg;

    localparam int MUL_LAT_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXEC1   = 3'd2,
        ST_MULWAIT = 3'd3,
        ST_EXEC2   = 3'd4,
        ST_MEM     = 3'd5,
        ST_HALT    = 3'd6
    } seq_state_t;

    // Opcode map, taken from instruction register bits [15:10]
    localparam logic [5:0] OP_JMP_FIRST  = 6'b000000;
    localparam logic [5:0] OP_JMP_LAST   = 6'b001011;
    localparam logic [5:0] OP_ALU_FIRST  = 6'b001100;
    localparam logic [5:0] OP_ALU_LAST   = 6'b011011;
    localparam logic [5:0] OP_MUL        = 6'b011100;
    localparam logic [5:0] OP_MLA        = 6'b011101;
    localparam logic [5:0] OP_MLS        = 6'b011110;
    localparam logic [5:0] OP_ALU_EXT    = 6'b011111;
    localparam logic [5:0] OP_ALU2_FIRST = 6'b100000;
    localparam logic [5:0] OP_ALU2_LAST  = 6'b100101;
    localparam logic [5:0] OP_PSH        = 6'b101000;
    localparam logic [5:0] OP_POP        = 6'b101001;
    localparam logic [5:0] OP_LDR        = 6'b110000;
    localparam logic [5:0] OP_STR        = 6'b110001;
    localparam logic [5:0] OP_NOP        = 6'b111110;
    localparam logic [5:0] OP_STP        = 6'b111111;

    function automatic logic op_in_range(input logic [5:0] op,
                                         input logic [5:0] lo,
                                         input logic [5:0] hi);
        return (op >= lo) && (op <= hi);
    endfunction

    function automatic logic is_jump_op(input logic [5:0] op);
        return op_in_range(op, OP_JMP_FIRST, OP_JMP_LAST);
    endfunction

    function automatic logic is_alu_op(input logic [5:0] op);
        return op_in_range(op, OP_ALU_FIRST, OP_ALU_LAST)
            || (op == OP_ALU_EXT)
            || op_in_range(op, OP_ALU2_FIRST, OP_ALU2_LAST);
    endfunction

    function automatic logic is_mul_op(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_MLA) || (op == OP_MLS);
    endfunction

endpackage

// File: rtl/seq_wait_cnt.sv
// 4-bit loadable down-counter used to time the multiplier wait; flags a count of one.
module seq_wait_cnt
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       one
);

    logic [3:0] cnt_d;
    logic [3:0] cnt_q;

    // Load has priority; decrement stops at zero so the counter never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign one = (cnt_q == 4'd1);

endmodule

// File: rtl/cpu_sequencer.sv
// CPU control sequencer: fetch/execute FSM with multi-cycle multiply and memory
// phases; control strobes decode from the state register, opcode and jump flag.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       jump,
    input  logic       mem_ack,
    output logic       ir_load,
    output logic       alu_en_n,
    output logic       exec2,
    output logic       reg_we,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       stk_push,
    output logic       stk_pop,
    output logic       mem_req,
    output logic       mem_we,
    output logic       halted
);

    localparam logic [3:0] MUL_LAT_CNT = 4'(MUL_LAT);

    seq_state_t state_d;
    seq_state_t state_q;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_one;

    seq_wait_cnt u_wait_cnt (
        .clk      (CLK),
        .rst_n    (nRST),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (MUL_LAT_CNT),
        .one      (cnt_one)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        ir_load  = 1'b0;
        alu_en_n = 1'b1;
        exec2    = 1'b0;
        reg_we   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                ir_load = 1'b1;
                state_d = ST_EXEC1;
            end

            ST_EXEC1: begin
                // Loads and stores keep the ALU idle; everything else uses it
                alu_en_n = (opcode == OP_LDR) || (opcode == OP_STR);
                state_d  = ST_FETCH;
                if (is_jump_op(opcode)) begin
                    pc_load = jump;
                    pc_inc  = !jump;
                end else if (is_alu_op(opcode)) begin
                    reg_we = 1'b1;
                    pc_inc = 1'b1;
                end else if (is_mul_op(opcode)) begin
                    cnt_load = 1'b1;
                    state_d  = ST_MULWAIT;
                end else begin
                    case (opcode)
                        OP_PSH: begin
                            stk_push = 1'b1;
                            pc_inc   = 1'b1;
                        end
                        OP_POP: begin
                            stk_pop = 1'b1;
                            reg_we  = 1'b1;
                            pc_inc  = 1'b1;
                        end
                        OP_LDR, OP_STR: begin
                            state_d = ST_MEM;
                        end
                        OP_STP: begin
                            reg_we  = 1'b1;
                            state_d = ST_HALT;
                        end
                        OP_NOP: begin
                            pc_inc = 1'b1;
                        end
                        default: begin
                            pc_inc = 1'b1;
                        end
                    endcase
                end
            end

            ST_MULWAIT: begin
                alu_en_n = 1'b0;
                cnt_dec  = 1'b1;
                if (cnt_one) begin
                    state_d = ST_EXEC2;
                end
            end

            ST_EXEC2: begin
                exec2    = 1'b1;
                alu_en_n = 1'b0;
                reg_we   = 1'b1;
                pc_inc   = 1'b1;
                state_d  = ST_FETCH;
            end

            // An ack already present on the first MEM cycle completes immediately
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_STR);
                if (mem_ack) begin
                    reg_we  = (opcode == OP_LDR);
                    pc_inc  = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed scoreboard bench for cpu_sequencer with MUL_LAT = 3; each step queues the
// expected control vector for the current cycle and compares it off the clock edge.
module tb_cpu_sequencer;

    logic       CLK;
    logic       nRST;
    logic       run;
    logic [5:0] opcode;
    logic       jump;
    logic       mem_ack;
    logic       ir_load;
    logic       alu_en_n;
    logic       exec2;
    logic       reg_we;
    logic       pc_inc;
    logic       pc_load;
    logic       stk_push;
    logic       stk_pop;
    logic       mem_req;
    logic       mem_we;
    logic       halted;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];
    logic [10:0] obs;

    // Vector order: ir_load alu_en_n exec2 reg_we pc_inc pc_load stk_push stk_pop mem_req mem_we halted
    localparam logic [10:0] E_IDLE    = 11'b01000000000;
    localparam logic [10:0] E_FETCH   = 11'b11000000000;
    localparam logic [10:0] E_ALU     = 11'b00011000000;
    localparam logic [10:0] E_JT      = 11'b00000100000;
    localparam logic [10:0] E_JN      = 11'b00001000000;
    localparam logic [10:0] E_MULX    = 11'b00000000000;
    localparam logic [10:0] E_MW      = 11'b00000000000;
    localparam logic [10:0] E_EX2     = 11'b00111000000;
    localparam logic [10:0] E_LSX     = 11'b01000000000;
    localparam logic [10:0] E_LD_WAIT = 11'b01000000100;
    localparam logic [10:0] E_LD_ACK  = 11'b01011000100;
    localparam logic [10:0] E_ST_ACK  = 11'b01001000110;
    localparam logic [10:0] E_PSH     = 11'b00001010000;
    localparam logic [10:0] E_POP     = 11'b00011001000;
    localparam logic [10:0] E_NOP     = 11'b00001000000;
    localparam logic [10:0] E_STP     = 11'b00010000000;
    localparam logic [10:0] E_HALT    = 11'b01000000001;

    localparam logic [5:0] ADD = 6'b010100;
    localparam logic [5:0] JC1 = 6'b000100;
    localparam logic [5:0] MUL = 6'b011100;
    localparam logic [5:0] MLS = 6'b011110;
    localparam logic [5:0] LDR = 6'b110000;
    localparam logic [5:0] STR = 6'b110001;
    localparam logic [5:0] PSH = 6'b101000;
    localparam logic [5:0] POP = 6'b101001;
    localparam logic [5:0] NOP = 6'b111110;
    localparam logic [5:0] UND = 6'b100110;
    localparam logic [5:0] STP = 6'b111111;

    assign obs = {ir_load, alu_en_n, exec2, reg_we, pc_inc, pc_load,
                  stk_push, stk_pop, mem_req, mem_we, halted};

    cpu_sequencer #(.MUL_LAT(3)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .run      (run),
        .opcode   (opcode),
        .jump     (jump),
        .mem_ack  (mem_ack),
        .ir_load  (ir_load),
        .alu_en_n (alu_en_n),
        .exec2    (exec2),
        .reg_we   (reg_we),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .halted   (halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic rst_v, input logic run_v,
                                 input logic [5:0] op_v, input logic jmp_v,
                                 input logic ack_v, input logic [10:0] e,
                                 input string t);
        @(negedge CLK);
        nRST    = rst_v;
        run     = run_v;
        opcode  = op_v;
        jump    = jmp_v;
        mem_ack = ack_v;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic checkOutput();
        logic [10:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%b expected=%b", t, obs, e);
        end
    endtask

    task automatic step(input logic rst_v, input logic run_v,
                        input logic [5:0] op_v, input logic jmp_v,
                        input logic ack_v, input logic [10:0] e,
                        input string t);
        applyStimulus(rst_v, run_v, op_v, jmp_v, ack_v, e, t);
        #1;
        checkOutput();
    endtask

    initial begin
        nRST    = 1'b0;
        run     = 1'b0;
        opcode  = 6'd0;
        jump    = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge CLK);

        step(0, 1, ADD, 0, 0, E_IDLE,    "reset_idle");
        step(1, 0, ADD, 0, 0, E_IDLE,    "idle_hold");
        step(1, 1, ADD, 0, 0, E_IDLE,    "idle_run");
        step(1, 0, ADD, 0, 0, E_FETCH,   "add_fetch");
        step(1, 0, ADD, 0, 0, E_ALU,     "add_exec1");
        step(1, 0, JC1, 1, 0, E_FETCH,   "jc1t_fetch");
        step(1, 0, JC1, 1, 0, E_JT,      "jc1_taken");
        step(1, 0, JC1, 0, 0, E_FETCH,   "jc1n_fetch");
        step(1, 0, JC1, 0, 0, E_JN,      "jc1_not_taken");
        step(1, 0, MUL, 0, 0, E_FETCH,   "mul_fetch");
        step(1, 0, MUL, 0, 0, E_MULX,    "mul_exec1");
        step(1, 0, MUL, 0, 0, E_MW,      "mul_wait1");
        step(1, 0, MUL, 0, 0, E_MW,      "mul_wait2");
        step(1, 0, MUL, 0, 0, E_MW,      "mul_wait3");
        step(1, 0, MUL, 0, 0, E_EX2,     "mul_exec2");
        step(1, 0, LDR, 0, 0, E_FETCH,   "ldr_fetch");
        step(1, 0, LDR, 0, 0, E_LSX,     "ldr_exec1");
        for (int i = 0; i < 4; i++) begin
            step(1, 0, LDR, 0, 0, E_LD_WAIT, "ldr_mem_wait");
        end
        step(1, 0, LDR, 0, 1, E_LD_ACK,  "ldr_mem_ack");
        step(1, 0, STR, 0, 1, E_FETCH,   "str_fetch_ack_ignored");
        step(1, 0, STR, 0, 1, E_LSX,     "str_exec1_ack_ignored");
        step(1, 0, STR, 0, 1, E_ST_ACK,  "str_mem_ack_on_entry");
        step(1, 0, PSH, 0, 0, E_FETCH,   "psh_fetch");
        step(1, 0, PSH, 0, 0, E_PSH,     "psh_exec1");
        step(1, 0, POP, 0, 0, E_FETCH,   "pop_fetch");
        step(1, 0, POP, 0, 0, E_POP,     "pop_exec1");
        step(1, 0, NOP, 0, 0, E_FETCH,   "nop_fetch");
        step(1, 0, NOP, 0, 0, E_NOP,     "nop_exec1");
        step(1, 0, UND, 0, 0, E_FETCH,   "undef_fetch");
        step(1, 0, UND, 0, 0, E_NOP,     "undef_exec1");
        step(1, 0, MLS, 0, 0, E_FETCH,   "mls_fetch");
        step(1, 0, MLS, 0, 0, E_MULX,    "mls_exec1");
        step(1, 0, MLS, 0, 0, E_MW,      "mls_wait1");
        step(0, 0, MLS, 0, 0, E_MW,      "mls_wait2_reset");
        step(1, 0, ADD, 0, 0, E_IDLE,    "after_reset_idle");
        step(1, 1, ADD, 0, 0, E_IDLE,    "restart_run");
        step(1, 0, ADD, 0, 0, E_FETCH,   "restart_fetch");
        step(1, 0, ADD, 0, 0, E_ALU,     "restart_exec1");
        step(1, 0, STP, 0, 0, E_FETCH,   "stp_fetch");
        step(1, 0, STP, 0, 0, E_STP,     "stp_exec1");
        step(1, 1, STP, 0, 1, E_HALT,    "halt_run_ack");
        step(1, 0, STP, 0, 0, E_HALT,    "halt_quiet");
        step(1, 1, STP, 0, 1, E_HALT,    "halt_run_ack2");
        step(0, 0, STP, 0, 0, E_HALT,    "halt_before_reset");
        step(1, 0, STP, 0, 0, E_IDLE,    "halt_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
